regfile_dump: RTL and testbench
===============================

# regfile_dump

Sequential read-out engine for the 32 × 64-bit register file of the single-cycle LEGv8 datapath. On a start pulse it drives the register file's asynchronous read-address port through addresses 0..NREGS-1 and streams each word out over a valid/ready interface, for a debug/trace port or a testbench scoreboard. While busy it requests a datapath hold so the dump is a consistent snapshot.

## Interface
- NREGS, 32: number of registers dumped, addresses 0..NREGS-1; legal range 1..32.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin a dump; sampled only in IDLE.
- ra  out  5  register-file read address; connect to ra1 or ra2.
- rd  in  64  register-file read data; combinational function of ra.
- out_valid  out  1  out_data/out_addr hold a beat.
- out_ready  in  1  consumer accepts the beat.
- out_data  out  64  register value, or checksum on the checksum beat.
- out_addr  out  5  register index of the beat; 0 on the checksum beat.
- out_last  out  1  marks the final beat of a dump.
- out_sum  out  1  marks the checksum beat; tied 0 without REGDUMP_CHECKSUM_EN.
- busy  out  1  high from the cycle after start is accepted through the DONE cycle.
- hold_req  out  1  equals busy; datapath must suppress we3 while high.
- done  out  1  one-cycle pulse after the final handshake.

## Operation
- States: IDLE, LOAD, SEND, DONE. Index register idx is 5 bits; ra = idx in every state.
- IDLE: idx = 0. start = 1 -> LOAD. start in any other state is ignored.
- LOAD: one cycle. out_data <= rd, out_addr <= idx, out_valid <= 1, out_last <= (idx == NREGS-1 and no checksum), sum ^= rd -> SEND.
- SEND: hold out_valid and all out_* stable until out_valid & out_ready.
  - On handshake: if idx < NREGS-1, then idx++ and go to LOAD.
  - If idx == NREGS-1, go to the checksum beat (macro) or DONE.
  - out_valid drops to 0 on the handshake edge.
- Checksum beat (macro only): out_data = XOR of all dumped words, out_addr = 0, out_sum = 1, out_last = 1. Same SEND rules apply.
- DONE: done = 1 for exactly one cycle -> IDLE. busy stays high during DONE.
- The checksum accumulator clears in IDLE. idx never wraps past NREGS-1.
- Reset, including mid-dump: state goes to IDLE and idx, sum and all outputs go to 0. Any in-flight beat is dropped without a handshake.

## Timing
- Reset values: out_valid, out_last, out_sum, busy, hold_req and done are 0; out_data, out_addr and ra are 0.
- start sampled at edge E0. LOAD occupies the cycle after E0. out_valid is high after E1.
- With out_ready held at 1, beat k is valid after edge E(2k+1) and handshakes at E(2k+2). Throughput is one beat per 2 cycles.
- NREGS = 32, no checksum: last handshake at E64. done is high in the cycle after E64, and the block is in IDLE after E65.
- With checksum: last handshake at E66.
- out_ready low stretches SEND indefinitely with no data change. out_ready may be high before out_valid; that is not a handshake.

## Configuration
- REGDUMP_CHECKSUM_EN defined: one extra checksum beat is appended after register NREGS-1. Only the checksum beat carries out_last.
- REGDUMP_CHECKSUM_EN undefined: there is no accumulator and no extra beat. out_sum is constant 0, and out_last marks register NREGS-1.

## Test plan
- Register file at reset contents (Xi = i, X31 = 0), out_ready = 1, pulse start -> 32 beats with out_addr 0..31 and out_data 0..30 followed by 0. out_last is high on addr 31. done is high in the cycle after E64.
- Same setup with REGDUMP_CHECKSUM_EN -> 33rd beat has out_data = 64'd31, out_sum = 1, out_last = 1. done is high in the cycle after E66.
- out_ready low for 5 cycles on beat 3 -> out_data = 3 and out_addr = 3 held stable for all 5 cycles. No beat is skipped or duplicated.
- start pulsed again at beat 10 -> ignored. Exactly 32 beats and one done pulse.
- reset asserted while in SEND at beat 7 -> the next cycle shows out_valid = 0, busy = 0, ra = 0. A new start dumps again from addr 0.
- Write X5 = 64'hDEAD before start, then run the dump with hold_req gating we3 -> beat 5 carries 64'hDEAD. we3 stays suppressed while busy.

Source files
------------

// File: rtl/regfile_dump.sv
// regfile_dump: streams the LEGv8 register file out over valid/ready.
// Optional checksum beat enabled by defining REGDUMP_CHECKSUM_EN.
module regfile_dump #(
    parameter int NREGS = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [4:0]  ra,
    input  logic [63:0] rd,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic [4:0]  out_addr,
    output logic        out_last,
    output logic        out_sum,
    output logic        busy,
    output logic        hold_req,
    output logic        done
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND,
        CLOAD,
        DONE
    } state_t;

    localparam logic [4:0] LAST = 5'(NREGS - 1);

    state_t      state;
    state_t      state_nxt;
    logic [4:0]  idx;
    logic        hs;
    logic        at_last;

    assign hs      = out_valid & out_ready;
    assign at_last = (idx == LAST);

`ifdef REGDUMP_CHECKSUM_EN
    logic [63:0] sum;
`else
    assign out_sum = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                state_nxt = SEND;
            end
            SEND: begin
                if (hs) begin
`ifdef REGDUMP_CHECKSUM_EN
                    if (out_sum) begin
                        state_nxt = DONE;
                    end else if (!at_last) begin
                        state_nxt = LOAD;
                    end else begin
                        state_nxt = CLOAD;
                    end
`else
                    if (!at_last) begin
                        state_nxt = LOAD;
                    end else begin
                        state_nxt = DONE;
                    end
`endif
                end
            end
            CLOAD: begin
                state_nxt = SEND;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State-decoded status outputs; address port follows the index
    always_comb begin
        busy     = (state != IDLE);
        hold_req = (state != IDLE);
        done     = (state == DONE);
        ra       = idx;
    end

    // Index and output beat registers
    always_ff @(posedge clk) begin
        if (reset) begin
            idx       <= 5'd0;
            out_valid <= 1'b0;
            out_data  <= 64'd0;
            out_addr  <= 5'd0;
            out_last  <= 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
            out_sum   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    idx <= 5'd0;
                end
                LOAD: begin
                    out_data  <= rd;
                    out_addr  <= idx;
                    out_valid <= 1'b1;
`ifdef REGDUMP_CHECKSUM_EN
                    out_last  <= 1'b0;
                    out_sum   <= 1'b0;
`else
                    out_last  <= at_last;
`endif
                end
                SEND: begin
                    if (hs) begin
                        out_valid <= 1'b0;
                        if (!at_last) begin
                            idx <= idx + 5'd1;
                        end
                    end
                end
`ifdef REGDUMP_CHECKSUM_EN
                CLOAD: begin
                    out_data  <= sum;
                    out_addr  <= 5'd0;
                    out_valid <= 1'b1;
                    out_last  <= 1'b1;
                    out_sum   <= 1'b1;
                end
`endif
                default: begin
                end
            endcase
        end
    end

`ifdef REGDUMP_CHECKSUM_EN
    // XOR accumulator over every word loaded, cleared while idle
    always_ff @(posedge clk) begin
        if (reset) begin
            sum <= 64'd0;
        end else if (state == IDLE) begin
            sum <= 64'd0;
        end else if (state == LOAD) begin
            sum <= sum ^ rd;
        end
    end
`endif

endmodule

// File: tb/tb_regfile_dump.sv
// tb_regfile_dump: directed bench for regfile_dump with a register file model.
// Build with REGDUMP_CHECKSUM_EN to exercise the checksum beat.
module tb_regfile_dump;

`ifdef REGDUMP_CHECKSUM_EN
    localparam int NB   = 33;
    localparam int LHS  = 66;
`else
    localparam int NB   = 32;
    localparam int LHS  = 64;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [4:0]  ra;
    logic [63:0] rd;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [4:0]  out_addr;
    logic        out_last;
    logic        out_sum;
    logic        busy;
    logic        hold_req;
    logic        done;

    logic        rf_init;
    logic        we3_req;
    logic        we3;
    logic [4:0]  wa;
    logic [63:0] wd;
    logic [63:0] rf [32];
    logic [63:0] exp_rf [32];

    typedef struct {
        logic [4:0]  a;
        logic [63:0] d;
        logic        l;
        logic        s;
        int          t;
    } beat_t;

    beat_t q[$];
    beat_t b;
    int    cyc = 0;
    int    done_n = 0;
    int    done_t = 0;
    int    nvec = 0;
    int    nmis = 0;
    int    e0;
    int    d0;

    always #5 clk = ~clk;

    regfile_dump #(.NREGS(32)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .ra(ra),
        .rd(rd),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_addr(out_addr),
        .out_last(out_last),
        .out_sum(out_sum),
        .busy(busy),
        .hold_req(hold_req),
        .done(done)
    );

    // Register file: async read, X31 reads zero, write gated by hold
    assign we3 = we3_req & ~hold_req;
    assign rd  = (ra == 5'd31) ? 64'd0 : rf[ra];

    always @(posedge clk) begin
        if (rf_init) begin
            for (int i = 0; i < 32; i++) rf[i] <= 64'(i);
        end else if (we3 && wa != 5'd31) begin
            rf[wa] <= wd;
        end
    end

    // Handshake and done monitor
    always @(posedge clk) begin
        cyc++;
        if (!reset && out_valid && out_ready) begin
            b.a = out_addr;
            b.d = out_data;
            b.l = out_last;
            b.s = out_sum;
            b.t = cyc;
            q.push_back(b);
        end
        if (!reset && done) begin
            done_n++;
            done_t = cyc;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        nvec++;
        if (obs !== exp) begin
            nmis++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int maxc);
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < maxc; k++) begin
            tick();
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        chk({tag, " done"}, 64'(seen), 64'd1);
    endtask

    task automatic wait_beat(input string tag, input logic [4:0] a);
        logic f;
        f = 1'b0;
        for (int k = 0; k < 80; k++) begin
            tick();
            if (out_valid && out_addr == a) begin
                f = 1'b1;
                break;
            end
        end
        chk({tag, " find"}, 64'(f), 64'd1);
    endtask

    task automatic check_dump(input string tag);
        logic [63:0] x;
        x = 64'd0;
        chk({tag, " nbeats"}, 64'(q.size()), 64'(NB));
        for (int i = 0; i < 32 && i < q.size(); i++) begin
            chk($sformatf("%s a%0d", tag, i), 64'(q[i].a), 64'(i));
            chk($sformatf("%s d%0d", tag, i), q[i].d, exp_rf[i]);
`ifdef REGDUMP_CHECKSUM_EN
            chk($sformatf("%s l%0d", tag, i), 64'(q[i].l), 64'd0);
`else
            chk($sformatf("%s l%0d", tag, i), 64'(q[i].l), 64'(i == 31));
`endif
            chk($sformatf("%s s%0d", tag, i), 64'(q[i].s), 64'd0);
            x ^= exp_rf[i];
        end
`ifdef REGDUMP_CHECKSUM_EN
        if (q.size() > 32) begin
            chk({tag, " csum d"}, q[32].d, x);
            chk({tag, " csum a"}, 64'(q[32].a), 64'd0);
            chk({tag, " csum s"}, 64'(q[32].s), 64'd1);
            chk({tag, " csum l"}, 64'(q[32].l), 64'd1);
        end
`endif
    endtask

    initial begin
        reset     = 1'b1;
        rf_init   = 1'b1;
        start     = 1'b0;
        out_ready = 1'b1;
        we3_req   = 1'b0;
        wa        = 5'd0;
        wd        = 64'd0;
        for (int i = 0; i < 32; i++) exp_rf[i] = 64'(i);
        exp_rf[31] = 64'd0;
        repeat (3) tick();
        rf_init = 1'b0;

        chk("rst valid", 64'(out_valid), 64'd0);
        chk("rst last", 64'(out_last), 64'd0);
        chk("rst sum", 64'(out_sum), 64'd0);
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst hold", 64'(hold_req), 64'd0);
        chk("rst done", 64'(done), 64'd0);
        chk("rst data", out_data, 64'd0);
        chk("rst addr", 64'(out_addr), 64'd0);
        chk("rst ra", 64'(ra), 64'd0);
        reset = 1'b0;
        tick();

        // Idle with ready high: no beats
        q.delete();
        repeat (4) tick();
        chk("idle beats", 64'(q.size()), 64'd0);

        // Plain dump with timing
        q.delete();
        d0 = done_n;
        pulse_start();
        e0 = cyc;
        chk("t1 busy e0", 64'(busy), 64'd1);
        chk("t1 hold e0", 64'(hold_req), 64'd1);
        chk("t1 valid e0", 64'(out_valid), 64'd0);
        tick();
        chk("t1 valid e1", 64'(out_valid), 64'd1);
        chk("t1 addr e1", 64'(out_addr), 64'd0);
        chk("t1 data e1", out_data, 64'd0);
        wait_done("t1", 100);
        tick();
        chk("t1 idle", 64'(busy), 64'd0);
        chk("t1 ndone", 64'(done_n), 64'(d0 + 1));
        chk("t1 done t", 64'(done_t - e0), 64'(LHS + 1));
        if (q.size() > 0)
            chk("t1 last hs", 64'(q[q.size() - 1].t - e0), 64'(LHS));
        check_dump("t1");

        // Backpressure on beat 3
        q.delete();
        pulse_start();
        wait_beat("t2", 5'd3);
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("t2 v%0d", k), 64'(out_valid), 64'd1);
            chk($sformatf("t2 d%0d", k), out_data, 64'd3);
            chk($sformatf("t2 a%0d", k), 64'(out_addr), 64'd3);
        end
        out_ready = 1'b1;
        wait_done("t2", 100);
        tick();
        check_dump("t2");

        // Second start mid-dump is ignored
        q.delete();
        d0 = done_n;
        pulse_start();
        wait_beat("t3", 5'd10);
        pulse_start();
        wait_done("t3", 100);
        tick();
        check_dump("t3");
        repeat (3) tick();
        chk("t3 ndone", 64'(done_n), 64'(d0 + 1));
        chk("t3 idle", 64'(busy), 64'd0);

        // Reset while a beat is pending
        q.delete();
        pulse_start();
        wait_beat("t4", 5'd7);
        out_ready = 1'b0;
        d0 = done_n;
        tick();
        chk("t4 pend", 64'(out_valid), 64'd1);
        reset = 1'b1;
        tick();
        chk("t4 valid", 64'(out_valid), 64'd0);
        chk("t4 busy", 64'(busy), 64'd0);
        chk("t4 ra", 64'(ra), 64'd0);
        chk("t4 addr", 64'(out_addr), 64'd0);
        reset = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("t4 nodone", 64'(done_n), 64'(d0));
        q.delete();
        pulse_start();
        wait_done("t4", 100);
        tick();
        check_dump("t4");

        // Write before dump lands; writes during dump are held off
        wa = 5'd5;
        wd = 64'hDEAD;
        we3_req = 1'b1;
        tick();
        we3_req = 1'b0;
        exp_rf[5] = 64'hDEAD;
        q.delete();
        pulse_start();
        wd = 64'hBEEF;
        we3_req = 1'b1;
        chk("t5 hold", 64'(hold_req), 64'd1);
        chk("t5 we3", 64'(we3), 64'd0);
        wait_done("t5", 100);
        we3_req = 1'b0;
        tick();
        check_dump("t5");
        chk("t5 x5", rf[5], 64'hDEAD);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
